rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
- Parametrised N-channel, WIDTH-bit arbitrating multiplexer; successor to the team's fixed 4:1 combinational mux.
- Each input channel offers data with a valid/ready handshake.
- The block selects one requesting channel per transfer, using fixed-priority or round-robin mode, and presents the data through a single registered output stage with its own valid/ready handshake.
- Sits between multiple producers and one shared consumer, such as a bus or display driver.

Parameters:
- N_CH, 4, number of input channels (2..16).
- WIDTH, 8, data width per channel in bits.
- CW, $clog2(N_CH), width of the channel index (derived; not to be overridden).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = fixed priority (lowest index wins), 1 = round robin.
- in_data  input  N_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel request.
- in_ready  output  N_CH  per-channel accept, one-hot or zero.
- out_data  output  WIDTH  registered selected data.
- out_ch  output  CW  index of the channel that supplied out_data.
- out_valid  output  1  output register holds valid data.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- Reset values, applied asynchronously while rst=1: out_data=0, out_ch=0, out_valid=0, round-robin pointer ptr=0.
- Output stage is free when out_valid=0, or when out_valid=1 and out_ready=1 (pass-through in the same cycle).

Grant (combinational from ptr, mode and in_valid):
- mode=0: the lowest index i with in_valid[i]=1.
- mode=1: the first i with in_valid[i]=1, scanning ptr, ptr+1, … N_CH-1, 0, … ptr-1 (wrap-around).
- No request means no grant.
- in_ready[i] = grant[i] AND stage free. At most one bit is set. in_ready is 0 for every channel when no channel is valid.

Input transfer (in_valid[g]=1 and in_ready[g]=1 at a clock edge):
- out_data <= in_data[g].
- out_ch <= g.
- out_valid <= 1.
- Latency is 1 cycle from input transfer to out_valid.

Output handling:
- Output transfer with no new input transfer: out_valid <= 0. out_data and out_ch hold their last value.
- Output transfer and input transfer in the same cycle: the new data replaces the old one. out_valid stays 1, with no bubble.
- Output stall (out_valid=1, out_ready=0): out_data, out_ch and out_valid hold stable, and all in_ready=0.

Pointer:
- Updates only on an input transfer: ptr <= (g+1) mod N_CH. The modulo is explicit for non-power-of-2 N_CH.
- In mode=0, ptr still updates this way but does not affect the grant.

Other rules:
- A mode change takes effect on the next grant evaluation. An in-flight output is unaffected.
- Inputs are sampled only on transfer. A producer dropping in_valid before transfer is legal and has no effect.
- Reset asserted mid-stream: outputs clear immediately, and pending out_data is discarded. After reset is released, the first grant starts from ptr=0.
- Throughput is one transfer per cycle while out_ready=1 and any channel is valid.

Test Plan:
- Reset: rst=1 mid-transfer with out_valid=1 → out_valid, out_data and out_ch drop to 0 asynchronously, before the next clk edge. ptr=0 after release.
- Fixed priority: mode=0, in_valid=4'b1010, data ch1=8'h11, ch3=8'h33, out_ready=1 → out_data is 8'h11 (out_ch=1) on every cycle while ch1 stays valid. Ch3 is never granted until ch1 drops, then 8'h33 and out_ch=3.
- Round robin: mode=1, all four valid with data 8'hA0..8'hA3, out_ready=1 → out_ch sequence 0,1,2,3,0 on consecutive cycles, and out_data follows A0,A1,A2,A3,A0.
- Round robin, sparse with wrap: mode=1, ptr=3 after a ch2 transfer, in_valid=4'b0101 → grant ch0 (wrap-around), then ch2, then ch0.
- Backpressure: out_valid=1, out_data=8'h55, out_ready=0 for 3 cycles while ch2 is valid with 8'h77 → out_data stays 8'h55, in_ready=0. When out_ready=1: 8'h55 is consumed and 8'h77 is loaded on the same edge, with out_valid continuous.
- Parametrisation: N_CH=3, WIDTH=16, mode=1, all valid → out_ch sequence 0,1,2,0. ptr never reaches 3, and 16-bit data is passed intact (e.g. 16'hBEEF on ch2).

Source files
------------

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux: N producer channels on one side,
// a single registered consumer port on the other.
interface rr_arb_mux_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(N_CH);

  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [CW-1:0]         out_ch;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_ch,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_ch,
    output out_valid
  );
endinterface

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating multiplexer: fixed-priority or round-robin grant
// feeding one registered valid/ready output stage with same-cycle refill.
module rr_arb_mux #(
  parameter int  N_CH  = 4,
  parameter int  WIDTH = 8,
  localparam int CW    = $clog2(N_CH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  rr_arb_mux_if.slave bus
);
  localparam int            SW   = CW + 1;
  localparam logic [SW-1:0] N_SW = SW'(N_CH);

  logic [CW-1:0]     ptr_q, ptr_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [CW-1:0]     out_ch_q, out_ch_d;
  logic              out_valid_q, out_valid_d;

  logic [CW-1:0]     start_idx;
  logic [2*N_CH-1:0] req_dbl;
  logic [N_CH-1:0]   req_rot;
  logic [SW-1:0]     off_idx;
  logic [SW-1:0]     sum_idx;
  logic [CW-1:0]     grant_idx;
  logic              grant_any;
  logic              stage_free;
  logic              in_xfer;
  logic [N_CH-1:0]   ready_vec;

  // Rotate the request vector so the scan always starts at bit 0; fixed
  // priority is just round robin with the start pinned to channel 0.
  assign start_idx = mode ? ptr_q : '0;
  assign req_dbl   = {bus.in_valid, bus.in_valid};
  assign req_rot   = req_dbl[start_idx +: N_CH];

  always_comb begin
    off_idx   = '0;
    grant_any = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        off_idx   = SW'(k);
        grant_any = 1'b1;
      end
    end
  end

  // Undo the rotation with an explicit wrap so non-power-of-2 N_CH works.
  assign sum_idx    = SW'(start_idx) + off_idx;
  assign grant_idx  = (sum_idx >= N_SW) ? CW'(sum_idx - N_SW) : CW'(sum_idx);

  assign stage_free = !out_valid_q || bus.out_ready;
  assign in_xfer    = grant_any && stage_free;

  always_comb begin
    ready_vec = '0;
    if (in_xfer) begin
      ready_vec[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (in_xfer) begin
      out_data_d  = bus.in_data[int'(grant_idx) * WIDTH +: WIDTH];
      out_ch_d    = grant_idx;
      out_valid_d = 1'b1;
      ptr_d       = (({1'b0, grant_idx} + 1'b1) == N_SW) ? '0 : grant_idx + CW'(1);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = ready_vec;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: a 4x8 and a 3x16 instance checked against a scan-based
// reference model, plus a table of hand-derived vectors and reset/parameter sequences.
module tb_rr_arb_mux;
  typedef struct {
    bit         md;
    logic [3:0] vld;
    logic [31:0] dat;
    bit         rdy;
    logic [3:0] exp_ready;
    bit         exp_valid;
    logic [7:0] exp_data;
    logic [1:0] exp_ch;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic mode_a, mode_b;

  int n_checks = 0;
  int n_fail   = 0;

  bit          md_v  [2];
  logic [3:0]  vld_v [2];
  logic [15:0] dat_v [2][4];
  bit          rdy_v [2];
  int          nch   [2];

  bit          m_valid [2];
  logic [15:0] m_data  [2];
  int          m_ch    [2];
  int          m_ptr   [2];
  logic [3:0]  seen_ready [2];

  vec_t tbl [20];

  rr_arb_mux_if #(.N_CH(4), .WIDTH(8))  bus_a ();
  rr_arb_mux_if #(.N_CH(3), .WIDTH(16)) bus_b ();

  rr_arb_mux #(.N_CH(4), .WIDTH(8)) dut_a (
    .clk  (clk),
    .rst  (rst),
    .mode (mode_a),
    .bus  (bus_a)
  );

  rr_arb_mux #(.N_CH(3), .WIDTH(16)) dut_b (
    .clk  (clk),
    .rst  (rst),
    .mode (mode_b),
    .bus  (bus_b)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int pick(int n, bit md, logic [3:0] vld, int ptr);
    int start;
    start = md ? ptr : 0;
    for (int k = 0; k < n; k++) begin
      if (vld[(start + k) % n]) return (start + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [3:0] readReady(int d);
    return (d == 0) ? bus_a.in_ready : {1'b0, bus_b.in_ready};
  endfunction

  function automatic bit readValid(int d);
    return (d == 0) ? bus_a.out_valid : bus_b.out_valid;
  endfunction

  function automatic logic [15:0] readData(int d);
    return (d == 0) ? {8'h00, bus_a.out_data} : bus_b.out_data;
  endfunction

  function automatic int readCh(int d);
    return (d == 0) ? int'(bus_a.out_ch) : int'(bus_b.out_ch);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0;
      m_data[d]  = '0;
      m_ch[d]    = 0;
      m_ptr[d]   = 0;
    end
  endtask

  task automatic driveBuses();
    mode_a          = md_v[0];
    bus_a.in_valid  = vld_v[0];
    bus_a.out_ready = rdy_v[0];
    for (int i = 0; i < 4; i++) bus_a.in_data[i*8 +: 8] = dat_v[0][i][7:0];
    mode_b          = md_v[1];
    bus_b.in_valid  = vld_v[1][2:0];
    bus_b.out_ready = rdy_v[1];
    for (int i = 0; i < 3; i++) bus_b.in_data[i*16 +: 16] = dat_v[1][i];
  endtask

  task automatic applyStimulus(input int d, input bit md, input logic [3:0] vld,
                               input logic [63:0] dat, input bit rdy);
    md_v[d]  = md;
    vld_v[d] = vld;
    rdy_v[d] = rdy;
    for (int i = 0; i < 4; i++) dat_v[d][i] = dat[i*16 +: 16];
    driveBuses();
  endtask

  // One clock: check in_ready before the edge, advance the model on the edge,
  // check the registered outputs just after it.
  task automatic runCycle();
    int         g      [2];
    bit         free_v [2];
    logic [3:0] exp_rdy;
    string      tag;
    #1;
    for (int d = 0; d < 2; d++) begin
      tag       = (d == 0) ? "A" : "B";
      free_v[d] = !m_valid[d] || rdy_v[d];
      g[d]      = pick(nch[d], md_v[d], vld_v[d], m_ptr[d]);
      exp_rdy   = (g[d] >= 0 && free_v[d]) ? 4'(1 << g[d]) : 4'b0000;
      seen_ready[d] = readReady(d);
      checkOutput({tag, ".in_ready"}, 32'(seen_ready[d]), 32'(exp_rdy));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (g[d] >= 0 && free_v[d]) begin
        m_data[d]  = (d == 0) ? {8'h00, dat_v[d][g[d]][7:0]} : dat_v[d][g[d]];
        m_ch[d]    = g[d];
        m_valid[d] = 1'b1;
        m_ptr[d]   = (g[d] + 1) % nch[d];
      end else if (m_valid[d] && rdy_v[d]) begin
        m_valid[d] = 1'b0;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      tag = (d == 0) ? "A" : "B";
      checkOutput({tag, ".out_valid"}, 32'(readValid(d)), 32'(m_valid[d]));
      checkOutput({tag, ".out_data"},  32'(readData(d)),  32'(m_data[d]));
      checkOutput({tag, ".out_ch"},    32'(readCh(d)),    32'(m_ch[d]));
    end
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] d64;
    logic [3:0]  r_vld;
    bit          r_md, r_rdy;
    int          exp_b_ch   [4];
    logic [15:0] exp_b_data [4];

    tbl[0]  = '{1'b0, 4'b1010, 32'h33001100, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    tbl[1]  = '{1'b0, 4'b1010, 32'h33001100, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    tbl[2]  = '{1'b0, 4'b1010, 32'h33001100, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    tbl[3]  = '{1'b0, 4'b1000, 32'h33001100, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3};
    tbl[4]  = '{1'b0, 4'b0000, 32'h33001100, 1'b1, 4'b0000, 1'b0, 8'h33, 2'd3};
    tbl[5]  = '{1'b1, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    tbl[6]  = '{1'b1, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    tbl[7]  = '{1'b1, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    tbl[8]  = '{1'b1, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    tbl[9]  = '{1'b1, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    tbl[10] = '{1'b1, 4'b0100, 32'h00220005, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd2};
    tbl[11] = '{1'b1, 4'b0101, 32'h00220005, 1'b1, 4'b0001, 1'b1, 8'h05, 2'd0};
    tbl[12] = '{1'b1, 4'b0101, 32'h00220005, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd2};
    tbl[13] = '{1'b1, 4'b0101, 32'h00220005, 1'b1, 4'b0001, 1'b1, 8'h05, 2'd0};
    tbl[14] = '{1'b1, 4'b0010, 32'h00005500, 1'b1, 4'b0010, 1'b1, 8'h55, 2'd1};
    tbl[15] = '{1'b1, 4'b0100, 32'h00770000, 1'b0, 4'b0000, 1'b1, 8'h55, 2'd1};
    tbl[16] = '{1'b1, 4'b0100, 32'h00770000, 1'b0, 4'b0000, 1'b1, 8'h55, 2'd1};
    tbl[17] = '{1'b1, 4'b0100, 32'h00770000, 1'b0, 4'b0000, 1'b1, 8'h55, 2'd1};
    tbl[18] = '{1'b1, 4'b0100, 32'h00770000, 1'b1, 4'b0100, 1'b1, 8'h77, 2'd2};
    tbl[19] = '{1'b1, 4'b0000, 32'h00770000, 1'b1, 4'b0000, 1'b0, 8'h77, 2'd2};

    nch[0] = 4;
    nch[1] = 3;
    rst    = 1'b1;
    resetModel();
    applyStimulus(0, 1'b0, 4'b0000, 64'h0, 1'b1);
    applyStimulus(1, 1'b0, 4'b0000, 64'h0, 1'b1);
    repeat (2) @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      checkOutput("reset.out_valid", 32'(readValid(d)), 32'h0);
      checkOutput("reset.out_data",  32'(readData(d)),  32'h0);
      checkOutput("reset.out_ch",    32'(readCh(d)),    32'h0);
    end
    rst = 1'b0;

    $display("[TB] table vectors on 4x8 instance");
    for (int r = 0; r < 20; r++) begin
      d64 = '0;
      for (int i = 0; i < 4; i++) d64[i*16 +: 16] = {8'h00, tbl[r].dat[i*8 +: 8]};
      applyStimulus(0, tbl[r].md, tbl[r].vld, d64, tbl[r].rdy);
      runCycle();
      checkOutput($sformatf("tbl[%0d].in_ready", r), 32'(seen_ready[0]), 32'(tbl[r].exp_ready));
      checkOutput($sformatf("tbl[%0d].out_valid", r), 32'(readValid(0)), 32'(tbl[r].exp_valid));
      checkOutput($sformatf("tbl[%0d].out_data", r), 32'(readData(0)), 32'(tbl[r].exp_data));
      checkOutput($sformatf("tbl[%0d].out_ch", r), 32'(readCh(0)), 32'(tbl[r].exp_ch));
    end

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(0, 1'b1, 4'b1111, 64'h00A3_00A2_00A1_00A0, 1'b1);
    runCycle();
    runCycle();
    checkOutput("rst.pre_valid", 32'(readValid(0)), 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst.async_valid", 32'(readValid(0)), 32'h0);
    checkOutput("rst.async_data",  32'(readData(0)),  32'h0);
    checkOutput("rst.async_ch",    32'(readCh(0)),    32'h0);
    resetModel();
    @(negedge clk);
    rst = 1'b0;
    runCycle();
    checkOutput("rst.first_ch",   32'(readCh(0)),   32'h0);
    checkOutput("rst.first_data", 32'(readData(0)), 32'hA0);

    $display("[TB] 3x16 round robin sequence");
    applyStimulus(0, 1'b0, 4'b0000, 64'h0, 1'b1);
    applyStimulus(1, 1'b1, 4'b0111, 64'h0000_BEEF_2222_1111, 1'b1);
    exp_b_ch   = '{0, 1, 2, 0};
    exp_b_data = '{16'h1111, 16'h2222, 16'hBEEF, 16'h1111};
    for (int k = 0; k < 4; k++) begin
      runCycle();
      checkOutput($sformatf("B.seq[%0d].out_ch", k), 32'(readCh(1)), 32'(exp_b_ch[k]));
      checkOutput($sformatf("B.seq[%0d].out_data", k), 32'(readData(1)), 32'(exp_b_data[k]));
    end

    $display("[TB] randomized traffic on both instances");
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        r_md  = 1'($urandom_range(0, 1));
        r_vld = 4'($urandom);
        r_rdy = ($urandom_range(0, 3) != 0);
        d64   = {$urandom, $urandom};
        applyStimulus(d, r_md, r_vld, d64, r_rdy);
      end
      runCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
